// File: rtl/mesi_pkg.sv
// Shared MESI definitions: listener state codes, snoop event one-hots, bus op codes.
// Ports: none (package only).
// Helper op_event maps a snooped bus op to the listener event it raises on a hit.
package mesi_pkg;

  // Listener line states
  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;

  // CPU_event one-hots {inv,wh,wm,rh,rm}
  localparam logic [4:0] EV_RM  = 5'b00001;
  localparam logic [4:0] EV_RH  = 5'b00010;
  localparam logic [4:0] EV_WM  = 5'b00100;
  localparam logic [4:0] EV_WH  = 5'b01000;
  localparam logic [4:0] EV_INV = 5'b10000;

  // Shared-bus op codes
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  // Remote read/write appear to the listener as its own miss events.
  function automatic logic [4:0] op_event(input logic [1:0] op);
    case (op)
      OP_RD:   return EV_RM;
      OP_WR:   return EV_WM;
      OP_INV:  return EV_INV;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Snoop queue: DEPTH-entry FIFO with wrap-around pointers (one extra lap bit).
// Ports: CLK/CLR, push/push_dat, pop/pop_dat (head, valid when !empty), full, empty.
// Push while full and pop while empty are ignored; simultaneous push+pop is allowed.
module snoop_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Same index, different lap bit => writer is one full lap ahead.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/snoop_event_gen.sv
// Snoop event generator: queues remote bus transactions, tag-checks them against the
// local line and emits one-cycle CPU_event/Controle pulses to the MESI listener.
// Ports: bus_* (valid/ready in), line_tag/line_state/wb_done (listener side),
// Controle/CPU_event (event out), busy, hit_cnt, wb_err (status).
module snoop_event_gen #(
  parameter int ADDR_W     = 16,
  parameter int TAG_W      = 10,
  parameter int ID_W       = 2,
  parameter int CORE_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int WB_TIMEOUT = 63
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [1:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [ID_W-1:0]   bus_src,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [2:0]        line_state,
  input  logic              wb_done,
  output logic              Controle,
  output logic [4:0]        CPU_event,
  output logic              busy,
  output logic [15:0]       hit_cnt,
  output logic              wb_err
);
  import mesi_pkg::*;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOOKUP  = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_WB_WAIT = 2'd3;

  localparam int PW    = ADDR_W + 2;
  localparam int WB_CW = $clog2(WB_TIMEOUT + 1);

  logic [1:0]       state;
  logic [1:0]       hold_op;
  logic [TAG_W-1:0] hold_tag;
  logic             wb_need;
  logic [WB_CW-1:0] wb_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [PW-1:0]    head;
  logic             hit;
  logic             unused_head_lo;

  // No bypass: ready depends only on occupancy, never on a same-cycle pop.
  assign bus_ready = CLR & ~fifo_full;
  // Own-core and no-op transactions complete the handshake but are dropped.
  assign push = bus_valid & bus_ready & (bus_op != OP_NONE) & (bus_src != ID_W'(CORE_ID));
  // Only IDLE pops, so WB_WAIT naturally blocks the queue.
  assign pop  = (state == S_IDLE) & ~fifo_empty;
  assign busy = (state != S_IDLE) | ~fifo_empty;
  assign hit  = (hold_tag == line_tag) && (line_state != ST_I);

  // Only the tag part of the address takes part in the compare.
  assign unused_head_lo = ^head[ADDR_W-TAG_W-1:0];

  snoop_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PW)
  ) u_fifo (
    .CLK      (CLK),
    .CLR      (CLR),
    .push     (push),
    .push_dat ({bus_op, bus_addr}),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= S_IDLE;
      hold_op   <= OP_NONE;
      hold_tag  <= '0;
      wb_need   <= 1'b0;
      wb_cnt    <= '0;
      Controle  <= 1'b1;
      CPU_event <= 5'b00000;
      hit_cnt   <= 16'h0000;
      wb_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            hold_op  <= head[PW-1 -: 2];
            hold_tag <= head[ADDR_W-1 -: TAG_W];
            state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            Controle  <= 1'b0;
            CPU_event <= op_event(hold_op);
            // Losing a Modified line to a remote read/write forces a write-back;
            // an invalidate is never issued against a Modified owner.
            wb_need   <= (line_state == ST_M) && (hold_op != OP_INV);
            state     <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          Controle  <= 1'b1;
          CPU_event <= 5'b00000;
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          wb_cnt    <= '0;
          state     <= wb_need ? S_WB_WAIT : S_IDLE;
        end
        S_WB_WAIT: begin
          if (wb_done) begin
            state <= S_IDLE;
          end else if (wb_cnt == WB_CW'(WB_TIMEOUT - 1)) begin
            // WB_TIMEOUT cycles spent here without completion.
            wb_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            wb_cnt <= wb_cnt + WB_CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_event_gen.sv
module tb_snoop_event_gen;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [1:0]  bus_op = 2'b00;
  logic [15:0] bus_addr = 16'h0;
  logic [1:0]  bus_src = 2'b00;
  logic [9:0]  line_tag = 10'h0;
  logic [2:0]  line_state = 3'b001;
  logic        wb_done = 1'b0;
  logic        Controle;
  logic [4:0]  CPU_event;
  logic        busy;
  logic [15:0] hit_cnt;
  logic        wb_err;

  snoop_event_gen dut (
    .CLK(CLK), .CLR(CLR), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
    .line_tag(line_tag), .line_state(line_state), .wb_done(wb_done),
    .Controle(Controle), .CPU_event(CPU_event), .busy(busy),
    .hit_cnt(hit_cnt), .wb_err(wb_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int exp_hits = 0;
  logic [4:0] obs_q[$];
  logic [4:0] exp_q[$];

  // Event monitor: collects every issued event and checks the output shape.
  always @(negedge CLK) begin
    if (CLR) begin
      if (!Controle) obs_q.push_back(CPU_event);
      tests++;
      if (Controle ? (CPU_event != 5'b0) : !$onehot(CPU_event)) begin
        fails++;
        $display("FAIL event_shape: Controle=%b CPU_event=%b", Controle, CPU_event);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: event the listener should see for one transaction, from the rules alone.
  function automatic logic [4:0] model_ev(input logic [1:0] op, input logic [9:0] tag,
                                          input logic [1:0] src, input logic [9:0] lt,
                                          input logic [2:0] ls);
    if (op == 2'b00 || src == 2'd0 || tag != lt || ls == 3'b001) return 5'b00000;
    if (op == 2'b01) return 5'b00001;
    if (op == 2'b10) return 5'b00100;
    return 5'b10000;
  endfunction

  task automatic send(input logic [1:0] op, input logic [9:0] tag, input logic [1:0] src);
    logic acc;
    acc = 1'b0;
    bus_valid = 1'b1;
    bus_op    = op;
    bus_src   = src;
    bus_addr  = {tag, 6'($urandom)};
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus_ready;
      step();
    end
    bus_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    step();
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic wait_ev(input int cnt);
    int n;
    n = 0;
    while (obs_q.size() < cnt && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) begin
      tests++; fails++;
      $display("FAIL event_timeout: got %0d events expected %0d", obs_q.size(), cnt);
    end
  endtask

  task automatic pulse_wb();
    wb_done = 1'b1;
    step();
    wb_done = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [9:0] tag;
    logic [1:0] src;
    logic [9:0] lt;
    logic [2:0] ls;
    logic [4:0] exp_ev;
  } vec_t;

  vec_t vt[9];
  logic [1:0] burst_op[6];

  initial begin
    logic [4:0] got;
    logic [9:0] tg;
    logic [1:0] op;
    logic [1:0] src;

    vt[0] = '{2'b01, 10'h02A, 2'd1, 10'h02A, 3'b011, 5'b00001};
    vt[1] = '{2'b01, 10'h02A, 2'd1, 10'h02A, 3'b001, 5'b00000};
    vt[2] = '{2'b01, 10'h02B, 2'd1, 10'h02A, 3'b011, 5'b00000};
    vt[3] = '{2'b01, 10'h02A, 2'd0, 10'h02A, 3'b011, 5'b00000};
    vt[4] = '{2'b00, 10'h02A, 2'd2, 10'h02A, 3'b011, 5'b00000};
    vt[5] = '{2'b10, 10'h02A, 2'd3, 10'h02A, 3'b010, 5'b00100};
    vt[6] = '{2'b11, 10'h155, 2'd2, 10'h155, 3'b011, 5'b10000};
    vt[7] = '{2'b11, 10'h02A, 2'd1, 10'h02A, 3'b100, 5'b10000};
    vt[8] = '{2'b10, 10'h3FF, 2'd1, 10'h3FF, 3'b010, 5'b00100};
    burst_op[0] = 2'b10; burst_op[1] = 2'b01; burst_op[2] = 2'b11;
    burst_op[3] = 2'b10; burst_op[4] = 2'b01; burst_op[5] = 2'b11;

    // Reset state
    step(3);
    CLR = 1'b1;
    step();
    check("rst_controle", 32'(Controle), 32'd1);
    check("rst_event", 32'(CPU_event), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus_ready), 32'd1);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);

    // Single-transaction vectors
    for (int i = 0; i < 9; i++) begin
      line_tag = vt[i].lt;
      line_state = vt[i].ls;
      obs_q.delete();
      send(vt[i].op, vt[i].tag, vt[i].src);
      wait_idle();
      got = (obs_q.size() > 0) ? obs_q[0] : 5'b00000;
      check($sformatf("vec%0d_event", i), 32'(got), 32'(vt[i].exp_ev));
      check($sformatf("vec%0d_count", i), 32'(obs_q.size()), (vt[i].exp_ev != 0) ? 32'd1 : 32'd0);
      if (vt[i].exp_ev != 0) exp_hits++;
      check($sformatf("vec%0d_hit_cnt", i), 32'(hit_cnt), 32'(exp_hits));
    end

    // Write hit on Modified stalls the next entry until wb_done
    line_tag = 10'h02A;
    line_state = 3'b100;
    obs_q.delete();
    send(2'b10, 10'h02A, 2'd1);
    send(2'b01, 10'h02A, 2'd2);
    step(20);
    check("wb_stall_count", 32'(obs_q.size()), 32'd1);
    got = (obs_q.size() > 0) ? obs_q[0] : 5'b00000;
    check("wb_stall_event", 32'(got), 32'b00100);
    check("wb_stall_busy", 32'(busy), 32'd1);
    line_state = 3'b011;
    pulse_wb();
    wait_idle();
    check("wb_release_count", 32'(obs_q.size()), 32'd2);
    got = (obs_q.size() > 1) ? obs_q[1] : 5'b00000;
    check("wb_release_event", 32'(got), 32'b00001);
    exp_hits += 2;
    check("wb_hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    check("wb_err_clear", 32'(wb_err), 32'd0);

    // Write-back timeout
    line_state = 3'b100;
    obs_q.delete();
    send(2'b01, 10'h02A, 2'd3);
    wait_ev(1);
    exp_hits++;
    step(50);
    check("to_early_err", 32'(wb_err), 32'd0);
    check("to_early_busy", 32'(busy), 32'd1);
    step(20);
    check("to_err", 32'(wb_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    pulse_wb();
    check("to_err_sticky", 32'(wb_err), 32'd1);

    // Burst against a WB stall fills the queue
    line_state = 3'b100;
    obs_q.delete();
    for (int i = 0; i < 5; i++) send(burst_op[i], 10'h02A, 2'(1 + (i % 3)));
    step(4);
    check("burst_full_ready", 32'(bus_ready), 32'd0);
    check("burst_stall_count", 32'(obs_q.size()), 32'd1);
    line_state = 3'b011;
    pulse_wb();
    send(burst_op[5], 10'h02A, 2'd2);
    wait_idle();
    check("burst_count", 32'(obs_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      got = (obs_q.size() > i) ? obs_q[i] : 5'b00000;
      check($sformatf("burst_ev%0d", i), 32'(got),
            32'(model_ev(burst_op[i], 10'h02A, 2'd1, 10'h02A, 3'b011)));
    end
    exp_hits += 6;
    check("burst_hit_cnt", 32'(hit_cnt), 32'(exp_hits));

    // Randomized segments against the reference model (many FIFO wraps)
    for (int s = 0; s < 5; s++) begin
      line_tag = 10'($urandom);
      line_state = 3'($urandom_range(1, 3));
      obs_q.delete();
      exp_q.delete();
      for (int t = 0; t < 30; t++) begin
        op  = 2'($urandom);
        src = 2'($urandom);
        tg  = ($urandom_range(0, 1) == 0) ? line_tag : 10'($urandom);
        send(op, tg, src);
        got = model_ev(op, tg, src, line_tag, line_state);
        if (got != 5'b0) exp_q.push_back(got);
        step($urandom_range(0, 2));
      end
      wait_idle();
      check($sformatf("rand%0d_count", s), 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (obs_q.size() > i) ? obs_q[i] : 5'b00000;
        check($sformatf("rand%0d_ev%0d", s, i), 32'(got), 32'(exp_q[i]));
      end
      exp_hits += exp_q.size();
      check($sformatf("rand%0d_hit_cnt", s), 32'(hit_cnt), 32'(exp_hits));
    end

    // Async reset during WB_WAIT with entries queued
    line_tag = 10'h02A;
    line_state = 3'b100;
    obs_q.delete();
    send(2'b10, 10'h02A, 2'd1);
    wait_ev(1);
    for (int i = 0; i < 3; i++) send(2'b01, 10'h02A, 2'd2);
    step(3);
    CLR = 1'b0;
    #2;
    check("arst_ready_low", 32'(bus_ready), 32'd0);
    step(2);
    CLR = 1'b1;
    line_state = 3'b011;
    step();
    check("arst_controle", 32'(Controle), 32'd1);
    check("arst_event", 32'(CPU_event), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(bus_ready), 32'd1);
    check("arst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("arst_wb_err", 32'(wb_err), 32'd0);
    obs_q.delete();
    step(15);
    check("arst_discarded", 32'(obs_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
